pulse_rate_meter: RTL and testbench
===================================

Name: pulse_rate_meter

Overview:
Counts the pulse/tick stream that our divider-style time bases emit, at the receiving end. Input is a pulse stream from a sensor or a divider strobe, possibly asynchronous. Output is a per-window rate, a saturating running total and a window-valid strobe. The measurement window is its own internal gate counter running on the system clock. Sits between the step/pulse source and the display/BCD path.

Parameters:
WIN_CYCLES, 100000000, clk cycles per measurement window (1 s at 100 MHz); must be >= 4
CNT_W, 14, width of rate and total outputs
TOTAL_MAX, 9999, saturation value of total_count (fits four 7-seg digits)
THRESH, 32, rate value at or above which over_thresh asserts

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
en  input  1  measurement enable; low freezes counting and the window counter
clear_total  input  1  one-cycle request to zero total_count
pulse_in  input  1  raw pulse stream, asynchronous to clk, high >= 2 clk cycles
rate  output  CNT_W  pulses counted in last completed window (registered)
rate_valid  output  1  one-cycle strobe when rate updates
total_count  output  CNT_W  saturating total of pulses since reset/clear
over_thresh  output  1  high while rate >= THRESH
saturated  output  1  high while total_count == TOTAL_MAX

Behaviour:
- Reset (sync, active-high, highest priority): rate=0, rate_valid=0, total_count=0, over_thresh=0, saturated=0; sync flops, window counter, window accumulator all 0; FSM -> IDLE.
- Input path: 2-FF synchronizer, then edge register; one internal edge strobe per rising edge of the synced signal. Latency: pulse_in rising sampled at edge k -> strobe active in cycle k+2, counted at edge k+3. Synchronizer and edge register run even when en=0, so no false edge on re-enable.
- FSM states: IDLE, RUN, PAUSE.
  IDLE: counters held at 0; en=1 -> RUN.
  RUN: win_cnt increments 0..WIN_CYCLES-1; edge strobe increments acc and total. en=0 -> PAUSE.
  PAUSE: win_cnt and acc frozen; edges ignored, not counted; en=1 -> RUN, resuming from the frozen win_cnt.
- Window close: in RUN with win_cnt==WIN_CYCLES-1: rate<=acc+edge (edge in the closing cycle counts in that window), rate_valid=1 for exactly that cycle, acc<=0, win_cnt<=0. If en falls in the close cycle, the close still completes.
- acc saturates at 2^CNT_W-1; no wrap.
- total_count: +1 per counted edge, stops at TOTAL_MAX. clear_total zeroes it next edge. clear_total and an edge in the same cycle -> total=0 (clear wins, edge lost from total, still counted in acc).
- saturated = (total_count==TOTAL_MAX), registered with total. over_thresh = (rate>=THRESH), updated the same edge as rate.
- rate and over_thresh hold between window closes, including through PAUSE.

Optional Feature:
RATE_AVG_EN: when defined, rate is the mean of the last 4 completed windows: (sum of 4-entry history)>>2, truncated. History resets to 0, so the first 3 windows report a partial mean (e.g. a single window of 8 -> rate 2). over_thresh compares against the averaged rate. When undefined, rate is the raw last-window count and no history storage is built.

Test Plan:
- Reset: WIN_CYCLES=100, assert reset 3 cycles mid-run with acc=5 -> all outputs 0; FSM IDLE; first rate_valid 100 cycles after en=1.
- Basic rate: en=1, 10 pulses (4 high/4 low) inside window 1 -> rate_valid at cycle 99 of the window, rate=10, total_count=10, over_thresh=0.
- Boundary: pulse timed so its edge strobe lands in cycle win_cnt==99 -> counted in the closing window (rate=1), next window starts with acc=0.
- Pause: en low for 50 cycles mid-window, 3 pulses during pause -> not counted; window closes 50 cycles late; rate excludes the 3.
- Saturation/clear: preload by 10000 pulses -> total_count=9999, saturated=1; clear_total coincident with an edge -> total_count=0, saturated=0 next cycle.
- Threshold (+RATE_AVG_EN variant): 40 pulses/window -> over_thresh=1. With RATE_AVG_EN defined, windows of 40,0,0,0 -> rates 10,10,10,10 after each close, over_thresh stays 0.

Source files
------------

// File: rtl/pulse_rate_meter.sv
// Pulse rate meter: synchronizes an asynchronous pulse stream and counts rising edges per gate
// window, plus a saturating running total. Define RATE_AVG_EN to report a 4-window mean rate.
module pulse_rate_meter #(
   parameter int unsigned WIN_CYCLES = 100000000,
   parameter int unsigned CNT_W      = 14,
   parameter int unsigned TOTAL_MAX  = 9999,
   parameter int unsigned THRESH     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clear_total,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] rate,
   output logic             rate_valid,
   output logic [CNT_W-1:0] total_count,
   output logic             over_thresh,
   output logic             saturated
);

   localparam int unsigned      WinW    = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
   localparam logic [WinW-1:0]  WinLast = WinW'(WIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] AccMax  = '1;
   localparam logic [CNT_W-1:0] TotMax  = CNT_W'(TOTAL_MAX);
   localparam logic [CNT_W-1:0] ThrVal  = CNT_W'(THRESH);

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   state_e           state_q, state_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
   logic             strobe_q, strobe_d;
   logic [WinW-1:0]  win_q, win_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] rate_q, rate_d;
   logic             rate_valid_q, rate_valid_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic             over_q, over_d;
   logic             sat_q, sat_d;

   logic             closing, active, counted;
   logic [CNT_W-1:0] acc_inc, win_sum, new_rate;

`ifdef RATE_AVG_EN
   // Only the three previous windows are stored; the closing window is the fourth term.
   logic [CNT_W-1:0] hist_q [3];
   logic [CNT_W-1:0] hist_d [3];
   logic [CNT_W+1:0] avg_sum;
`endif

   always_comb begin
      sync1_d  = pulse_in;
      sync2_d  = sync1_q;
      sync3_d  = sync2_q;
      strobe_d = sync2_q & ~sync3_q;

      // A close that was already due completes even if en drops in that cycle.
      closing = (state_q == StRun) && (win_q == WinLast);
      active  = en | closing;
      counted = active & strobe_q;
      acc_inc = (acc_q == AccMax) ? acc_q : acc_q + CNT_W'(1);
      win_sum = counted ? acc_inc : acc_q;

`ifdef RATE_AVG_EN
      avg_sum  = (CNT_W+2)'(win_sum) + (CNT_W+2)'(hist_q[0]) + (CNT_W+2)'(hist_q[1])
               + (CNT_W+2)'(hist_q[2]);
      new_rate = CNT_W'(avg_sum >> 2);
      hist_d   = hist_q;
`else
      new_rate = win_sum;
`endif

      unique case (state_q)
         StIdle:  state_d = en ? StRun : StIdle;
         StRun:   state_d = en ? StRun : StPause;
         StPause: state_d = en ? StRun : StPause;
         default: state_d = StIdle;
      endcase

      win_d        = win_q;
      acc_d        = acc_q;
      rate_d       = rate_q;
      rate_valid_d = 1'b0;
      over_d       = over_q;
      if (active) begin
         if (win_q == WinLast) begin
            win_d        = '0;
            acc_d        = '0;
            rate_d       = new_rate;
            rate_valid_d = 1'b1;
            over_d       = (new_rate >= ThrVal);
`ifdef RATE_AVG_EN
            hist_d[2] = hist_q[1];
            hist_d[1] = hist_q[0];
            hist_d[0] = win_sum;
`endif
         end else begin
            win_d = win_q + WinW'(1);
            acc_d = win_sum;
         end
      end

      // Clear wins over a coincident edge; that edge still reaches acc.
      total_d = total_q;
      if (clear_total) begin
         total_d = '0;
      end else if (counted && (total_q != TotMax)) begin
         total_d = total_q + CNT_W'(1);
      end
      sat_d = (total_d == TotMax);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sync3_q      <= 1'b0;
         strobe_q     <= 1'b0;
         win_q        <= '0;
         acc_q        <= '0;
         rate_q       <= '0;
         rate_valid_q <= 1'b0;
         total_q      <= '0;
         over_q       <= 1'b0;
         sat_q        <= 1'b0;
`ifdef RATE_AVG_EN
         for (int i = 0; i < 3; i++) hist_q[i] <= '0;
`endif
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         sync3_q      <= sync3_d;
         strobe_q     <= strobe_d;
         win_q        <= win_d;
         acc_q        <= acc_d;
         rate_q       <= rate_d;
         rate_valid_q <= rate_valid_d;
         total_q      <= total_d;
         over_q       <= over_d;
         sat_q        <= sat_d;
`ifdef RATE_AVG_EN
         for (int i = 0; i < 3; i++) hist_q[i] <= hist_d[i];
`endif
      end
   end

   assign rate        = rate_q;
   assign rate_valid  = rate_valid_q;
   assign total_count = total_q;
   assign over_thresh = over_q;
   assign saturated   = sat_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Bench for pulse_rate_meter: directed and random pulse trains checked every cycle against a
// window/total reference model; honours RATE_AVG_EN.
module tb_pulse_rate_meter;

   localparam int unsigned W      = 100;
   localparam int unsigned CW     = 14;
   localparam int          TMAX   = 9999;
   localparam int          TH     = 32;
   localparam int          ACCMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset, en, clear_total, pulse_in;
   logic [CW-1:0] rate, total_count;
   logic          rate_valid, over_thresh, saturated;

   pulse_rate_meter #(
      .WIN_CYCLES(W),
      .CNT_W     (CW),
      .TOTAL_MAX (TMAX),
      .THRESH    (TH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .clear_total(clear_total),
      .pulse_in   (pulse_in),
      .rate       (rate),
      .rate_valid (rate_valid),
      .total_count(total_count),
      .over_thresh(over_thresh),
      .saturated  (saturated)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: pin history (ph[i] = pulse_in i cycles ago) and window bookkeeping.
   int ph[5];
   int m_run, m_win, m_acc, m_rate, m_valid, m_total, m_over, m_sat;
   int hist[4];

   task automatic chk(input string tag, input logic [CW-1:0] obs, input int exp);
      checks++;
      assert (obs === CW'(exp))
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_close(input int wsum);
`ifdef RATE_AVG_EN
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = wsum;
      m_rate  = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
      m_rate = wsum;
`endif
      m_over = (m_rate >= TH) ? 1 : 0;
   endtask

   task automatic model_update(input logic p, input logic e, input logic c, input logic r);
      int strobe, last, act, cnt;
      for (int i = 4; i > 0; i--) ph[i] = ph[i-1];
      ph[0] = int'(p);
      if (r) begin
         for (int i = 0; i < 5; i++) ph[i] = 0;
         for (int i = 0; i < 4; i++) hist[i] = 0;
         m_run = 0; m_win = 0; m_acc = 0; m_rate = 0; m_valid = 0;
         m_total = 0; m_over = 0; m_sat = 0;
         return;
      end
      // An edge reaches the counters three cycles after pulse_in first reads high.
      strobe  = (ph[3] == 1 && ph[4] == 0) ? 1 : 0;
      last    = (m_win == W - 1) ? 1 : 0;
      act     = (e || (m_run && last)) ? 1 : 0;
      cnt     = act & strobe;
      m_valid = 0;
      if (act) begin
         if (last) begin
            model_close((m_acc + cnt > ACCMAX) ? ACCMAX : m_acc + cnt);
            m_acc   = 0;
            m_win   = 0;
            m_valid = 1;
         end else begin
            m_win++;
            if (cnt && m_acc < ACCMAX) m_acc++;
         end
      end
      if (c) m_total = 0;
      else if (cnt && m_total < TMAX) m_total++;
      m_sat = (m_total == TMAX) ? 1 : 0;
      m_run = int'(e);
   endtask

   task automatic step(input logic p, input logic e, input logic c, input logic r);
      pulse_in    = p;
      en          = e;
      clear_total = c;
      reset       = r;
      @(posedge clk);
      model_update(p, e, c, r);
      #1;
      chk("rate", rate, m_rate);
      chk("rate_valid", rate_valid, m_valid);
      chk("total_count", total_count, m_total);
      chk("over_thresh", over_thresh, m_over);
      chk("saturated", saturated, m_sat);
   endtask

   task automatic idle(input int n, input logic e);
      for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 1'b0);
   endtask

   task automatic pulses(input int n, input int hi, input int lo, input logic e);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < hi; j++) step(1'b1, e, 1'b0, 1'b0);
         for (int j = 0; j < lo; j++) step(1'b0, e, 1'b0, 1'b0);
      end
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      for (int i = 0; i < budget; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         n++;
         if (rate_valid === 1'b1) return;
      end
      checks++;
      errors++;
      $error("FAIL valid_timeout observed=no_strobe expected=strobe_within_%0d", budget);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rate"}, rate, 0);
      chk({tag, "_valid"}, rate_valid, 0);
      chk({tag, "_total"}, total_count, 0);
      chk({tag, "_over"}, over_thresh, 0);
      chk({tag, "_sat"}, saturated, 0);
   endtask

   initial begin
      int k;
      int hi, lo, ce;
      logic e;
      pulse_in = 1'b0; en = 1'b0; clear_total = 1'b0; reset = 1'b1;
      for (int i = 0; i < 5; i++) ph[i] = 0;

      // Reset, then reset again in the middle of a run with five edges accumulated.
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_all_zero("reset");
      idle(2, 1'b0);
      pulses(5, 4, 4, 1'b1);
      idle(4, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
      chk_all_zero("reset_midrun");
      idle(2, 1'b0);

      // Basic rate: ten pulses in the first window.
      pulses(10, 4, 4, 1'b1);
      wait_valid(100, k);
      chk("first_valid_latency", CW'(80 + k), 100);
      chk("basic_rate", rate, 10);
      chk("basic_total", total_count, 10);
      chk("basic_over", over_thresh, 0);

      // Boundary: edge strobe lands in the closing cycle.
      for (int i = 0; i < W + 5 && m_win != W - 4; i++) idle(1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      wait_valid(10, k);
      chk("boundary_rate", rate, 1);
      wait_valid(W + 5, k);
      chk("boundary_next_len", CW'(k), W);
      chk("boundary_next_rate", rate, 0);

      // Pause: en low 50 cycles mid-window with three pulses ignored.
      pulses(2, 4, 6, 1'b1);
      idle(10, 1'b1);
      pulses(3, 4, 4, 1'b0);
      idle(26, 1'b0);
      wait_valid(200, k);
      chk("pause_len", CW'(80 + k), 150);
      chk("pause_rate", rate, 2);

      // Threshold: exactly THRESH pulses, then one fewer.
      pulses(32, 2, 1, 1'b1);
      wait_valid(10, k);
`ifdef RATE_AVG_EN
      chk("thresh_avg_over", over_thresh, 0);
`else
      chk("thresh_rate", rate, 32);
      chk("thresh_over", over_thresh, 1);
`endif
      pulses(31, 2, 1, 1'b1);
      wait_valid(10, k);
`ifndef RATE_AVG_EN
      chk("below_thresh_over", over_thresh, 0);
`endif

      // Random pulse widths, enable gaps and occasional clears.
      for (int i = 0; i < 400; i++) begin
         hi = int'($urandom_range(5, 2));
         lo = int'($urandom_range(6, 1));
         e  = ($urandom_range(9, 0) != 0);
         ce = ($urandom_range(49, 0) == 0) ? 1 : 0;
         for (int j = 0; j < hi; j++) step(1'b1, e, 1'b0, 1'b0);
         for (int j = 0; j < lo; j++) step(1'b0, e, (j == 0) && ce != 0, 1'b0);
      end

      // Saturation and clear coincident with an edge.
      step(1'b0, 1'b1, 1'b1, 1'b0);
      pulses(10005, 2, 2, 1'b1);
      chk("sat_total", total_count, TMAX);
      chk("sat_flag", saturated, 1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("clear_sat_total", total_count, 0);
      chk("clear_sat_flag", saturated, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("clear_wins_total", total_count, 0);
      idle(4, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
